// File: rtl/parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : parking_gate_ctrl
//  Description : Entry-lane sequencer for a car-park barrier. Arms when a car
//                sits at the front sensor, checks the keypad code, opens the
//                gate until the car passes the back sensor or a timeout
//                expires, tracks occupancy and locks the lane after repeated
//                wrong codes.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                fr_sens       - car waiting at the entry
//                bk_sens       - car has passed the gate
//                pswd/pswd_vld - keypad code and its one-cycle strobe
//                exit_evt      - one-cycle pulse per car leaving the lot
//                gate          - 1 = gate open
//                lock          - lane locked out
//                wrong         - one-cycle pulse per rejected code
//                full          - lot at capacity
//                count         - cars currently inside
//  Revision    : 1.0 - initial release
// ============================================================================
module parking_gate_ctrl #(
    parameter logic [7:0] PSWD         = 8'd194,
    parameter int         MAX_TRIES    = 3,
    parameter int         LOCK_CYCLES  = 16,
    parameter int         OPEN_TIMEOUT = 32,
    parameter int         CAPACITY     = 8,
    parameter int         CNT_W        = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fr_sens,
    input  logic             bk_sens,
    input  logic [7:0]       pswd,
    input  logic             pswd_vld,
    input  logic             exit_evt,
    output logic             gate,
    output logic             lock,
    output logic             wrong,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    // One timer serves both the open window and the lockout window.
    localparam int TMR_MAX = (OPEN_TIMEOUT > LOCK_CYCLES) ? OPEN_TIMEOUT : LOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);

    localparam logic [TMR_W-1:0] OPEN_LAST = TMR_W'(OPEN_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);
    localparam logic [CNT_W-1:0] CAP_VAL   = CNT_W'(CAPACITY);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_PSWD = 2'd1,
        OPEN      = 2'd2,
        LOCKED    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               gate_q, gate_d;
    logic               lock_q, lock_d;
    logic               wrong_q, wrong_d;
    logic               full_q, full_d;
    logic               pass_evt;
    logic               exit_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            tries_q <= '0;
            count_q <= '0;
            gate_q  <= 1'b0;
            lock_q  <= 1'b0;
            wrong_q <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            tries_q <= tries_d;
            count_q <= count_d;
            gate_q  <= gate_d;
            lock_q  <= lock_d;
            wrong_q <= wrong_d;
            full_q  <= full_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        tries_d  = tries_q;
        wrong_d  = 1'b0;
        pass_evt = 1'b0;

        case (state_q)
            IDLE: begin
                tries_d = '0;
                // Entry is refused while the lot is full.
                if (fr_sens && !full_q) begin
                    state_d = WAIT_PSWD;
                end
            end
            WAIT_PSWD: begin
                // A car backing away cancels any code entered on that cycle.
                if (!fr_sens) begin
                    state_d = IDLE;
                end else if (pswd_vld) begin
                    if (pswd == PSWD) begin
                        state_d = OPEN;
                        timer_d = '0;
                    end else begin
                        wrong_d = 1'b1;
                        tries_d = tries_q + TRY_W'(1);
                        if (tries_d == TRY_LIMIT) begin
                            state_d = LOCKED;
                            timer_d = '0;
                        end
                    end
                end
            end
            OPEN: begin
                timer_d = timer_q + TMR_W'(1);
                // A pass on the final timeout cycle still counts.
                if (bk_sens) begin
                    pass_evt = 1'b1;
                    state_d  = IDLE;
                end else if (timer_q == OPEN_LAST) begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                timer_d = timer_q + TMR_W'(1);
                if (timer_q == LOCK_LAST) begin
                    state_d = IDLE;
                    tries_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Simultaneous pass and exit cancel out; exits at zero are dropped.
        exit_ok = exit_evt && (count_q != '0);
        count_d = count_q;
        if (pass_evt && !exit_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (!pass_evt && exit_ok) begin
            count_d = count_q - CNT_W'(1);
        end

        // Outputs are decoded from next-state values so they register on the
        // same edge as the transition that causes them.
        full_d = (count_d == CAP_VAL);
        gate_d = (state_d == OPEN);
        lock_d = (state_d == LOCKED);
    end

    assign gate  = gate_q;
    assign lock  = lock_q;
    assign wrong = wrong_q;
    assign full  = full_q;
    assign count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_parking_gate_ctrl
//  Description : Directed bench for parking_gate_ctrl. The stimulus process
//                queues hand-computed expectations tagged with the clock edge
//                they apply to; a monitor samples on the falling edge and
//                compares against the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_gate_ctrl;

    localparam int CAP   = 8;
    localparam int CNT_W = 4;

    localparam int S_GATE  = 0;
    localparam int S_LOCK  = 1;
    localparam int S_WRONG = 2;
    localparam int S_FULL  = 3;
    localparam int S_COUNT = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             fr_sens = 1'b0;
    logic             bk_sens = 1'b0;
    logic [7:0]       pswd = 8'd0;
    logic             pswd_vld = 1'b0;
    logic             exit_evt = 1'b0;
    logic             gate;
    logic             lock;
    logic             wrong;
    logic             full;
    logic [CNT_W-1:0] count;

    parking_gate_ctrl #(
        .PSWD         (8'd194),
        .MAX_TRIES    (3),
        .LOCK_CYCLES  (16),
        .OPEN_TIMEOUT (32),
        .CAPACITY     (CAP),
        .CNT_W        (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .fr_sens  (fr_sens),
        .bk_sens  (bk_sens),
        .pswd     (pswd),
        .pswd_vld (pswd_vld),
        .exit_evt (exit_evt),
        .gate     (gate),
        .lock     (lock),
        .wrong    (wrong),
        .full     (full),
        .count    (count)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    typedef struct {
        int    tag;
        int    sig;
        int    val;
        string name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            S_GATE:  actual = {31'd0, gate};
            S_LOCK:  actual = {31'd0, lock};
            S_WRONG: actual = {31'd0, wrong};
            S_FULL:  actual = {31'd0, full};
            default: actual = {{(32-CNT_W){1'b0}}, count};
        endcase
    endfunction

    // Monitor: compare every expectation whose edge has just happened.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].tag <= edges) begin
                e   = q.pop_front();
                act = actual(e.sig);
                n_checks++;
                if (e.tag != edges || act !== 32'(e.val)) begin
                    n_fail++;
                    $display("FAIL %s edge %0d (checked at %0d): got %0d expected %0d",
                             e.name, e.tag, edges, act, e.val);
                end
            end
        end
    end

    // Expectation for the outputs right after the next rising edge.
    task automatic push(input string nm, input int sig, input int val);
        exp_t e;
        e.tag  = edges + 1;
        e.sig  = sig;
        e.val  = val;
        e.name = nm;
        q.push_back(e);
    endtask

    task automatic set_in(input logic fr, input logic bk, input logic pv,
                          input logic [7:0] pw, input logic ex);
        fr_sens  = fr;
        bk_sens  = bk;
        pswd_vld = pv;
        pswd     = pw;
        exit_evt = ex;
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    // Arm the lane and enter the correct code; gate opens after the code edge.
    task automatic enter();
        set_in(1, 0, 0, 8'd0, 0);
        push("arm_gate", S_GATE, 0);
        adv();
        set_in(1, 0, 1, 8'd194, 0);
        push("open_gate", S_GATE, 1);
        adv();
    endtask

    task automatic pass_car(input int exp_cnt);
        enter();
        set_in(0, 1, 0, 8'd0, 0);
        push("pass_gate", S_GATE, 0);
        push("pass_count", S_COUNT, exp_cnt);
        push("pass_full", S_FULL, (exp_cnt == CAP) ? 1 : 0);
        adv();
        set_in(0, 0, 0, 8'd0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        set_in(0, 0, 0, 8'd0, 0);
        rst = 1'b1;
        adv();
        push("rst_gate", S_GATE, 0);
        push("rst_lock", S_LOCK, 0);
        push("rst_wrong", S_WRONG, 0);
        push("rst_full", S_FULL, 0);
        push("rst_count", S_COUNT, 0);
        adv();
        rst = 1'b0;

        // Normal entry; code on the same edge fr rises is ignored
        set_in(1, 0, 1, 8'd194, 0);
        push("early_code_gate", S_GATE, 0);
        adv();
        set_in(1, 0, 1, 8'd194, 0);
        push("norm_open", S_GATE, 1);
        push("norm_wrong", S_WRONG, 0);
        adv();
        for (int i = 0; i < 6; i++) begin
            set_in(0, 0, 0, 8'd0, 0);
            push("norm_hold", S_GATE, 1);
            push("norm_cnt0", S_COUNT, 0);
            adv();
        end
        set_in(0, 1, 0, 8'd0, 0);
        push("norm_close", S_GATE, 0);
        push("norm_count", S_COUNT, 1);
        push("norm_full", S_FULL, 0);
        adv();
        set_in(0, 0, 0, 8'd0, 0);
        push("norm_idle", S_GATE, 0);
        adv();

        // Wrong-code lockout
        set_in(1, 0, 0, 8'd0, 0);
        adv();
        set_in(1, 0, 1, 8'd250, 0);
        push("wr1_wrong", S_WRONG, 1);
        push("wr1_lock", S_LOCK, 0);
        adv();
        set_in(1, 0, 0, 8'd0, 0);
        push("wr1_pulse_end", S_WRONG, 0);
        adv();
        set_in(1, 0, 1, 8'd255, 0);
        push("wr2_wrong", S_WRONG, 1);
        push("wr2_lock", S_LOCK, 0);
        adv();
        set_in(1, 0, 1, 8'd100, 0);
        push("wr3_wrong", S_WRONG, 1);
        push("wr3_lock", S_LOCK, 1);
        push("wr3_gate", S_GATE, 0);
        adv();
        for (int i = 1; i < 16; i++) begin
            set_in(1, 0, (i == 5), 8'd194, 0);
            push("lock_hold", S_LOCK, 1);
            push("lock_gate", S_GATE, 0);
            push("lock_wrong", S_WRONG, 0);
            adv();
        end
        set_in(1, 0, 0, 8'd0, 0);
        push("lock_release", S_LOCK, 0);
        push("lock_rel_gate", S_GATE, 0);
        adv();
        set_in(1, 0, 0, 8'd0, 0);
        push("rearm_lock", S_LOCK, 0);
        adv();
        // tries must have been cleared: two more misses must not lock
        set_in(1, 0, 1, 8'd7, 0);
        push("retry1_wrong", S_WRONG, 1);
        push("retry1_lock", S_LOCK, 0);
        adv();
        set_in(1, 0, 1, 8'd8, 0);
        push("retry2_wrong", S_WRONG, 1);
        push("retry2_lock", S_LOCK, 0);
        adv();
        // fr drops with a wrong code: attempt not counted
        set_in(0, 0, 1, 8'd9, 0);
        push("frdrop_wrong", S_WRONG, 0);
        push("frdrop_lock", S_LOCK, 0);
        adv();
        set_in(0, 0, 0, 8'd0, 0);
        push("frdrop_idle_lock", S_LOCK, 0);
        adv();

        // Gate timeout: high for exactly 32 cycles
        enter();
        for (int i = 1; i < 32; i++) begin
            set_in(0, 0, 0, 8'd0, 0);
            push("to_hold", S_GATE, 1);
            adv();
        end
        set_in(0, 0, 0, 8'd0, 0);
        push("to_close", S_GATE, 0);
        push("to_count", S_COUNT, 1);
        adv();

        // bk_sens on the timeout cycle still counts
        enter();
        for (int i = 1; i < 32; i++) begin
            set_in(0, 0, 0, 8'd0, 0);
            push("tobk_hold", S_GATE, 1);
            adv();
        end
        set_in(0, 1, 0, 8'd0, 0);
        push("tobk_close", S_GATE, 0);
        push("tobk_count", S_COUNT, 2);
        adv();
        set_in(0, 0, 0, 8'd0, 0);
        adv();

        // Fill the lot
        for (int i = 0; i < 6; i++) begin
            pass_car(3 + i);
        end
        set_in(1, 0, 0, 8'd0, 0);
        push("full_flag", S_FULL, 1);
        push("full_count", S_COUNT, 8);
        push("full_gate", S_GATE, 0);
        adv();
        set_in(1, 0, 1, 8'd194, 0);
        push("full_blocked", S_GATE, 0);
        adv();
        set_in(1, 0, 1, 8'd194, 0);
        push("full_blocked2", S_GATE, 0);
        adv();
        set_in(0, 0, 0, 8'd0, 1);
        push("exit_count", S_COUNT, 7);
        push("exit_full", S_FULL, 0);
        adv();
        pass_car(8);
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 8'd0, 1);
            push("drain_count", S_COUNT, 7 - i);
            adv();
        end

        // Pass and exit in the same cycle at count 5
        enter();
        set_in(0, 1, 0, 8'd0, 1);
        push("both_count", S_COUNT, 5);
        push("both_gate", S_GATE, 0);
        push("both_full", S_FULL, 0);
        adv();
        for (int i = 0; i < 7; i++) begin
            set_in(0, 0, 0, 8'd0, 1);
            push("exit_down", S_COUNT, (i < 5) ? 4 - i : 0);
            adv();
        end
        set_in(0, 0, 0, 8'd0, 0);
        adv();

        // Reset while the gate is open with three cars inside
        pass_car(1);
        pass_car(2);
        pass_car(3);
        enter();
        set_in(0, 0, 0, 8'd0, 0);
        push("pre_rst_gate", S_GATE, 1);
        push("pre_rst_count", S_COUNT, 3);
        adv();
        rst = 1'b1;
        push("mid_rst_gate", S_GATE, 0);
        push("mid_rst_count", S_COUNT, 0);
        push("mid_rst_lock", S_LOCK, 0);
        push("mid_rst_wrong", S_WRONG, 0);
        push("mid_rst_full", S_FULL, 0);
        adv();
        rst = 1'b0;
        // Back in IDLE: first code ignored, second opens
        set_in(1, 0, 1, 8'd194, 0);
        push("post_rst_idle", S_GATE, 0);
        adv();
        set_in(1, 0, 1, 8'd194, 0);
        push("post_rst_open", S_GATE, 1);
        adv();
        set_in(0, 1, 0, 8'd0, 0);
        push("post_rst_count", S_COUNT, 1);
        adv();
        set_in(0, 0, 0, 8'd0, 0);

        repeat (3) adv();
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/parking_gate_ctrl.md
# parking_gate_ctrl

Sequencing controller for the car-park entry gate. It detects a car at the front sensor, checks the password the driver enters, and opens the gate. It then closes the gate once the back sensor shows the car has passed, or when a timeout expires. It also keeps a count of cars inside, refuses entry when the lot is full, and locks out a lane after repeated wrong passwords. It sits between the lane sensors and keypad on one side and the gate actuator on the other.

## Interface

Parameters:
- PSWD, 8'd194: accepted password.
- MAX_TRIES, 3: wrong attempts allowed before lockout (≥1).
- LOCK_CYCLES, 16: lockout duration in clk cycles (≥1).
- OPEN_TIMEOUT, 32: maximum number of cycles the gate stays open (≥1).
- CAPACITY, 8: lot capacity.
- CNT_W, 4: occupancy counter width. Requires CAPACITY ≤ 2^CNT_W−1.

Ports:
- clk, input, 1: single clock; all logic acts on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- fr_sens, input, 1: car present at the entry (front sensor).
- bk_sens, input, 1: car has passed the gate (back sensor).
- pswd, input, 8: keypad code; valid only when pswd_vld=1.
- pswd_vld, input, 1: one-cycle strobe marking that a code has been entered.
- exit_evt, input, 1: one-cycle pulse per car leaving the lot.
- gate, output, 1: 1 = gate open, 0 = gate closed.
- lock, output, 1: lane is locked out.
- wrong, output, 1: one-cycle pulse on each rejected code.
- full, output, 1: count == CAPACITY.
- count, output, CNT_W: cars currently inside.

## Operation

- All outputs are registered.
- Reset values: state=IDLE, gate=0, lock=0, wrong=0, full=0, count=0, tries=0, timer=0.
- State IDLE:
  - gate=0, lock=0, tries=0.
  - If fr_sens=1 and full=0, go to WAIT_PSWD.
  - If fr_sens=1 and full=1, stay in IDLE.
  - pswd_vld is ignored in this state.
- State WAIT_PSWD:
  - If fr_sens=0, go to IDLE. This takes priority over any pswd_vld in the same cycle, and that attempt is not counted.
  - Else if pswd_vld=1 and pswd==PSWD, go to OPEN and clear the timer.
  - Else if pswd_vld=1 and the code mismatches, pulse wrong=1 and increment tries.
    - If the new tries value equals MAX_TRIES, go to LOCKED and clear the timer.
- State OPEN:
  - gate=1; timer increments each cycle.
  - If bk_sens=1, increment count and go to IDLE.
  - Else if timer reaches OPEN_TIMEOUT−1, go to IDLE with no count change.
  - If bk_sens=1 arrives on the timeout cycle, bk_sens wins.
- State LOCKED:
  - lock=1, gate=0; timer increments each cycle.
  - At timer = LOCK_CYCLES−1, go to IDLE and clear tries.
  - fr_sens and pswd_vld are ignored in this state.
- Occupancy counter:
  - +1 on an accepted pass (bk_sens in OPEN).
  - −1 on exit_evt when count>0.
  - Both in the same cycle: count is unchanged.
  - exit_evt with count=0: ignored.
  - Increment never exceeds CAPACITY, because entry is blocked when full.
  - exit_evt is honoured in every state.
- full is recomputed from the registered next value of count, so full and count change on the same edge.

## Timing

- Input to output latency is 1 cycle. Inputs sampled at edge N are reflected on the outputs after edge N.
- Correct code strobed at edge N: gate=1 from edge N to edge N+OPEN_TIMEOUT at most, i.e. high for exactly OPEN_TIMEOUT cycles if no bk_sens arrives.
- bk_sens sampled at edge M while in OPEN: after edge M, gate=0 and count has incremented.
- Final wrong code at edge N: after edge N, wrong=1 for one cycle and lock=1. lock stays high for exactly LOCK_CYCLES cycles.
- IDLE to WAIT_PSWD takes 1 cycle, so a code strobed on the same edge on which fr_sens first rises is ignored.
- Reset asserted mid-operation: on the next edge every output takes its reset value, including gate=0 and count=0, regardless of state.

## Test plan

- Normal entry: fr_sens=1, pswd=194 with pswd_vld at cycle 3, bk_sens at cycle 10 → gate=1 for cycles 4–10, gate=0 after edge 10, count 0→1, wrong never pulses.
- Wrong-code lockout: fr_sens=1, codes 250, 255, 100 → three wrong pulses; lock=1 for 16 cycles after the third; gate stays 0; a code of 194 strobed during lockout is ignored; IDLE is re-entered with tries=0.
- Gate timeout: correct code entered, bk_sens held at 0 → gate high for exactly 32 cycles, count unchanged.
- Full lot: drive 8 accepted passes → full=1; a new fr_sens plus code 194 leaves gate=0; one exit_evt gives count=7, full=0, and entry works again.
- Simultaneous and boundary events: bk_sens together with exit_evt at count=5 leaves count=5; exit_evt at count=0 leaves count=0; bk_sens on the timeout cycle increments count; fr_sens dropping in the same cycle as a wrong code gives no wrong pulse and tries unchanged.
- Reset mid-open: assert rst while gate=1 and count=3 → after the next edge gate=0, count=0, lock=0, state=IDLE.
